// File: rtl/fft_pkg.sv
// Shared types for the FFT address sequencer: controller state encoding and
// the bit-reverse helper used to scatter input samples into memory.
package fft_pkg;

    localparam int unsigned MaxLog2N = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StBfly,
        StUnload,
        StDone
    } fft_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MaxLog2N-1:0] bitrev(input logic [MaxLog2N-1:0] v,
                                                  input int unsigned w);
        logic [MaxLog2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MaxLog2N); i++) begin
            if (i < int'(w)) begin
                r = r | (MaxLog2N'(v[i]) << (int'(w) - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_seq_if.sv
// Control, load, butterfly and unload signals of the FFT address sequencer.
// The slave side is the sequencer; the master side is whoever drives it.
interface fft_addr_seq_if #(
    parameter int unsigned LOG2N = 8
);
    localparam int unsigned SW  = $clog2(LOG2N);
    localparam int unsigned TWW = LOG2N - 1;

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [SW-1:0]    stage;

    logic             in_valid;
    logic             in_ready;
    logic             ld_wren;
    logic [LOG2N-1:0] ld_addr;

    logic             bf_rden;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [TWW-1:0]   tw_addr;
    logic             bf_shift;

    logic             bf_wren;
    logic [LOG2N-1:0] bf_waddr_a;
    logic [LOG2N-1:0] bf_waddr_b;

    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] out_addr;

    modport master (
        output start, abort, in_valid, out_ready,
        input  busy, done, stage, in_ready, ld_wren, ld_addr,
               bf_rden, bf_addr_a, bf_addr_b, tw_addr, bf_shift,
               bf_wren, bf_waddr_a, bf_waddr_b, out_valid, out_addr
    );

    modport slave (
        input  start, abort, in_valid, out_ready,
        output busy, done, stage, in_ready, ld_wren, ld_addr,
               bf_rden, bf_addr_a, bf_addr_b, tw_addr, bf_shift,
               bf_wren, bf_waddr_a, bf_waddr_b, out_valid, out_addr
    );

endinterface

// File: rtl/fft_addr_dly.sv
// Fixed-depth delay line carrying butterfly read addresses to the writeback
// port; a synchronous clear flushes everything in flight.
module fft_addr_dly #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_addr_seq.sv
// Radix-2 in-place FFT address sequencer: bit-reversed load, per-stage
// butterfly issue with delayed writeback, then bin unload. Optional abort via
// FFT_ADDR_SEQ_ABORT_EN.
module fft_addr_seq
    import fft_pkg::*;
#(
    parameter int unsigned      LOG2N       = 8,
    parameter int unsigned      BF_LAT      = 2,
    parameter logic [LOG2N-1:0] SCALE_MASK  = '1,
    parameter int unsigned      UNLOAD_HALF = 1,
    parameter int unsigned      DONE_HOLD   = 4
) (
    input logic           clk,
    input logic           reset,
    fft_addr_seq_if.slave bus
);

    localparam int unsigned N         = 1 << LOG2N;
    localparam int unsigned HALF      = N / 2;
    localparam int unsigned STAGE_LEN = HALF + BF_LAT;
    localparam int unsigned SW        = $clog2(LOG2N);
    localparam int unsigned CW        = LOG2N + 1;
    localparam int unsigned TWW       = LOG2N - 1;
    localparam int unsigned DW        = $clog2(DONE_HOLD + 1);
    localparam int unsigned LAST      = (UNLOAD_HALF != 0) ? HALF : N - 1;
    localparam int unsigned DLY_W     = 1 + 2 * LOG2N;

    fft_state_e       state_q;
    logic [LOG2N-1:0] k_q;
    logic [LOG2N-1:0] ua_q;
    logic [SW-1:0]    s_q;
    logic [CW-1:0]    c_q;
    logic [DW-1:0]    dh_q;

    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             out_valid_q;
    logic             rd_q;
    logic             shift_q;
    logic [LOG2N-1:0] a_q;
    logic [LOG2N-1:0] b_q;
    logic [TWW-1:0]   tw_q;

    logic             ld_fire;
    logic             out_fire;
    logic             abort_hit;
    logic             kill;
    logic             nxt_en;
    logic [SW-1:0]    nxt_s;
    logic [LOG2N-1:0] nxt_b;
    logic [DLY_W-1:0] dly_q;

    function automatic logic [LOG2N-1:0] calc_a(input int s, input int b);
        int j;
        j = b & ((1 << s) - 1);
        return LOG2N'(((b >> s) << (s + 1)) + j);
    endfunction

    function automatic logic [LOG2N-1:0] calc_b(input int s, input int b);
        return LOG2N'(int'(calc_a(s, b)) + (1 << s));
    endfunction

    function automatic logic [TWW-1:0] calc_tw(input int s, input int b);
        return TWW'((b & ((1 << s) - 1)) << (int'(LOG2N) - 1 - s));
    endfunction

`ifdef FFT_ADDR_SEQ_ABORT_EN
    assign abort_hit = bus.abort && (state_q != StIdle);
`else
    logic unused_abort;
    assign unused_abort = bus.abort;
    assign abort_hit    = 1'b0;
`endif

    assign kill     = reset || abort_hit;
    assign ld_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Butterfly to present on the read port next cycle; each stage ends with
    // BF_LAT idle cycles so its last writeback lands before the next stage reads.
    always_comb begin
        nxt_en = 1'b0;
        nxt_s  = '0;
        nxt_b  = '0;
        case (state_q)
            StLoad: begin
                if (ld_fire && (k_q == LOG2N'(N - 1))) begin
                    nxt_en = 1'b1;
                end
            end
            StBfly: begin
                if (c_q == CW'(STAGE_LEN - 1)) begin
                    if (s_q != SW'(LOG2N - 1)) begin
                        nxt_en = 1'b1;
                        nxt_s  = s_q + SW'(1);
                    end
                end else if (int'(c_q) + 1 < int'(HALF)) begin
                    nxt_en = 1'b1;
                    nxt_s  = s_q;
                    nxt_b  = LOG2N'(c_q + CW'(1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q     <= StIdle;
            k_q         <= '0;
            ua_q        <= '0;
            s_q         <= '0;
            c_q         <= '0;
            dh_q        <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rd_q        <= 1'b0;
            shift_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            tw_q        <= '0;
        end else begin
            rd_q    <= nxt_en;
            a_q     <= nxt_en ? calc_a(int'(nxt_s), int'(nxt_b)) : '0;
            b_q     <= nxt_en ? calc_b(int'(nxt_s), int'(nxt_b)) : '0;
            tw_q    <= nxt_en ? calc_tw(int'(nxt_s), int'(nxt_b)) : '0;
            shift_q <= nxt_en && SCALE_MASK[nxt_s];

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StLoad;
                        k_q        <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_fire) begin
                        k_q <= k_q + LOG2N'(1);
                        if (k_q == LOG2N'(N - 1)) begin
                            state_q    <= StBfly;
                            in_ready_q <= 1'b0;
                            s_q        <= '0;
                            c_q        <= '0;
                        end
                    end
                end
                StBfly: begin
                    if (c_q == CW'(STAGE_LEN - 1)) begin
                        c_q <= '0;
                        if (s_q == SW'(LOG2N - 1)) begin
                            state_q     <= StUnload;
                            s_q         <= '0;
                            ua_q        <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                StUnload: begin
                    if (out_fire) begin
                        if (ua_q == LOG2N'(LAST)) begin
                            state_q     <= StDone;
                            ua_q        <= '0;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            dh_q        <= '0;
                        end else begin
                            ua_q <= ua_q + LOG2N'(1);
                        end
                    end
                end
                StDone: begin
                    if (dh_q == DW'(DONE_HOLD - 1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        dh_q    <= '0;
                    end else begin
                        dh_q <= dh_q + DW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fft_addr_dly #(
        .Width(DLY_W),
        .Depth(BF_LAT)
    ) u_dly (
        .clk_i(clk),
        .clr_i(kill),
        .d_i  ({rd_q, a_q, b_q}),
        .q_o  (dly_q)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stage      = s_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.ld_wren    = ld_fire;
    assign bus.ld_addr    = in_ready_q ? LOG2N'(bitrev(MaxLog2N'(k_q), LOG2N)) : '0;
    assign bus.bf_rden    = rd_q;
    assign bus.bf_addr_a  = a_q;
    assign bus.bf_addr_b  = b_q;
    assign bus.tw_addr    = tw_q;
    assign bus.bf_shift   = shift_q;
    assign bus.bf_wren    = dly_q[DLY_W-1];
    assign bus.bf_waddr_a = dly_q[2*LOG2N-1 -: LOG2N];
    assign bus.bf_waddr_b = dly_q[LOG2N-1:0];
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = ua_q;

endmodule
